// File: rtl/led_display_arbiter_if.sv
// Requester-side and led_matrix-side signals of the LED display arbiter.
// The master drives requests and frame ticks; the slave is the arbiter.
interface led_display_arbiter_if;
  logic        FRAME_TICK;
  logic        REQ0;
  logic [31:0] DATA0;
  logic        REQ1;
  logic [31:0] DATA1;
  logic        GNT0;
  logic        GNT1;
  logic        ACK0;
  logic        ACK1;
  logic [31:0] DATA;
  logic [3:0]  INTENSITY;
  logic        BUSY;

  modport master (
    output FRAME_TICK, REQ0, DATA0, REQ1, DATA1,
    input  GNT0, GNT1, ACK0, ACK1, DATA, INTENSITY, BUSY
  );

  modport slave (
    input  FRAME_TICK, REQ0, DATA0, REQ1, DATA1,
    output GNT0, GNT1, ACK0, ACK1, DATA, INTENSITY, BUSY
  );
endinterface

// File: rtl/led_display_arbiter.sv
// Round-robin owner of one LED matrix shared by two requesters. All updates happen on
// FRAME_TICK cycles only; ownership changes cross-fade through intensity zero.
module led_display_arbiter #(
  parameter int unsigned HOLD_FRAMES      = 200,
  parameter int unsigned FADE_STEP_FRAMES = 4,
  parameter int unsigned MAX_INTENSITY    = 15
) (
  input logic                  CLK,
  input logic                  RSTN,
  led_display_arbiter_if.slave bus
);

  localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned FrameW = $clog2(FADE_STEP_FRAMES + 1);

  localparam logic [HoldW-1:0]  HoldMax = HoldW'(HOLD_FRAMES);
  localparam logic [FrameW-1:0] StepCnt = FrameW'(FADE_STEP_FRAMES);
  localparam logic [3:0]        MaxInt  = 4'(MAX_INTENSITY);

  typedef enum logic [1:0] {StIdle, StFadeIn, StShow, StFadeOut} state_e;

  state_e            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        intensity_q, intensity_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [HoldW-1:0]  hold_q, hold_d;

  logic [1:0]        req;
  logic              own_req;
  logic              oth_req;
  logic [FrameW-1:0] frame_inc;
  logic              step;
  logic              load;
  logic              load_sel;

  assign req       = {bus.REQ1, bus.REQ0};
  assign own_req   = req[owner_q];
  assign oth_req   = req[~owner_q];
  assign frame_inc = frame_q + FrameW'(1);
  assign step      = (frame_inc == StepCnt);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    intensity_d = intensity_q;
    gnt_d       = gnt_q;
    ack_d       = 2'b00;
    owner_d     = owner_q;
    last_d      = last_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    load        = 1'b0;
    load_sel    = owner_q;

    if (bus.FRAME_TICK) begin
      case (state_q)
        StIdle: begin
          if (|req) begin
            load        = 1'b1;
            // Tie goes to the requester that did not win last time
            load_sel    = (&req) ? ~last_q : req[1];
            intensity_d = 4'd0;
            frame_d     = '0;
            hold_d      = '0;
            state_d     = StFadeIn;
          end
        end

        StFadeIn: begin
          frame_d = frame_inc;
          if (step) begin
            frame_d = '0;
            if (({1'b0, intensity_q} + 5'd1) >= {1'b0, MaxInt}) begin
              intensity_d = MaxInt;
              hold_d      = '0;
              state_d     = StShow;
            end else begin
              intensity_d = intensity_q + 4'd1;
            end
          end
        end

        StShow: begin
          if (own_req) begin
            load     = 1'b1;
            load_sel = owner_q;
          end
          if (hold_q != HoldMax) begin
            hold_d = hold_q + HoldW'(1);
          end
          // An abandoned display is handed over at once; a held one only after hold
          if (oth_req && (!own_req || (hold_q == HoldMax))) begin
            frame_d = '0;
            state_d = StFadeOut;
          end
        end

        StFadeOut: begin
          if (intensity_q == 4'd0) begin
            if (oth_req || own_req) begin
              load     = 1'b1;
              load_sel = oth_req ? ~owner_q : owner_q;
              frame_d  = '0;
              hold_d   = '0;
              state_d  = StFadeIn;
            end else begin
              gnt_d   = 2'b00;
              state_d = StIdle;
            end
          end else begin
            frame_d = frame_inc;
            if (step) begin
              frame_d     = '0;
              intensity_d = intensity_q - 4'd1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end

    if (load) begin
      data_d  = load_sel ? bus.DATA1 : bus.DATA0;
      ack_d   = load_sel ? 2'b10 : 2'b01;
      gnt_d   = load_sel ? 2'b10 : 2'b01;
      owner_d = load_sel;
      last_d  = load_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      data_q      <= '0;
      intensity_q <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      frame_q     <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      intensity_q <= intensity_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.GNT0      = gnt_q[0];
  assign bus.GNT1      = gnt_q[1];
  assign bus.ACK0      = ack_q[0];
  assign bus.ACK1      = ack_q[1];
  assign bus.DATA      = data_q;
  assign bus.INTENSITY = intensity_q;
  assign bus.BUSY      = (state_q == StFadeIn) || (state_q == StFadeOut);

endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
- Shares one 32-bit LED matrix display between two requesters, e.g. the random-pattern generator and a message source.
- Sits between the requesters and the led_matrix driver, and drives that driver's data and intensity inputs.
- Changes content only on the driver's frame_tick, so frames never tear.
- Cross-fades ownership changes: intensity ramps down to 0, the owner swaps, then intensity ramps back up.

Parameters:
- HOLD_FRAMES, 200: minimum frames an owner keeps the display before a contending requester can take it (>=1).
- FADE_STEP_FRAMES, 4: frames per one-step intensity change during a fade (>=1).
- MAX_INTENSITY, 15: intensity shown in SHOW state, 0-15.

Ports:
- CLK  in  1  system clock (12 MHz).
- RSTN  in  1  reset.
- FRAME_TICK  in  1  one-cycle pulse per completed scan frame, from led_matrix.
- REQ0  in  1  requester 0 wants the display (level).
- DATA0  in  32  requester 0 pattern.
- REQ1  in  1  requester 1 wants the display (level).
- DATA1  in  32  requester 1 pattern.
- GNT0  out  1  requester 0 owns the display.
- GNT1  out  1  requester 1 owns the display.
- ACK0  out  1  one-cycle pulse: DATA0 was latched.
- ACK1  out  1  one-cycle pulse: DATA1 was latched.
- DATA  out  32  pattern to led_matrix.
- INTENSITY  out  4  intensity to led_matrix.
- BUSY  out  1  high in FADE_IN and FADE_OUT.

Behaviour:
- Clocking and reset: single clock CLK; reset RSTN is synchronous and active-low. All state is registered on CLK.
- Reset values: state=IDLE, DATA=0, INTENSITY=0, GNT0=GNT1=0, ACK0=ACK1=0, BUSY=0, owner=0, last=1, frame counter=0, hold counter=0.
- Reset asserted mid-operation (any state, including mid-fade) forces all reset values on the next edge.
- Evaluation timing: all state transitions, counter updates and latches happen only on cycles where FRAME_TICK=1. Outputs are registered and change on the edge ending that cycle. Latency from the FRAME_TICK cycle to the new DATA/INTENSITY/ACK is 1 clock.
- ACK: asserted for exactly one cycle, on the same edge as the DATA load.
- Round-robin selection: when both REQ are high, the winner is the requester != last; otherwise the single requester wins. After reset (last=1), REQ0 wins a tie. On every grant, last is set to the new owner.
- IDLE (GNT=0, INTENSITY=0):
  - tick with any REQ: select owner, latch DATA, pulse ACK, set GNTowner=1, INTENSITY=0, clear counters, go to FADE_IN.
- FADE_IN:
  - Each tick, frame counter increments.
  - When frame counter reaches FADE_STEP_FRAMES: counter clears and INTENSITY increments.
  - When INTENSITY reaches MAX_INTENSITY: go to SHOW, clear hold counter.
  - MAX_INTENSITY=0: go to SHOW on the first step tick.
  - Owner REQ is not sampled during the fade.
- SHOW (INTENSITY=MAX_INTENSITY):
  - Each tick, if the owner's REQ is high, re-latch the owner's DATA and pulse its ACK (live update).
  - Hold counter increments, saturating at HOLD_FRAMES.
  - Owner REQ low and other REQ high: go to FADE_OUT immediately, ignoring hold.
  - Owner REQ high, other REQ high and hold counter == HOLD_FRAMES: go to FADE_OUT.
  - Both REQ low: remain in SHOW with the last DATA.
- FADE_OUT:
  - Decrement INTENSITY every FADE_STEP_FRAMES ticks.
  - On the tick where INTENSITY is already 0:
    - other REQ high: swap owner (GNT switches on that edge, never both high), latch, ACK, go to FADE_IN;
    - else owner REQ high: same owner, latch, ACK, go to FADE_IN;
    - else: GNT=0, go to IDLE, DATA retained.
- Invariants: GNT0 & GNT1 never both 1; INTENSITY never exceeds MAX_INTENSITY.
- FRAME_TICK stuck high: every cycle is treated as a frame; behaviour remains correct.
- Counter widths: hold counter is $clog2(HOLD_FRAMES+1); frame counter is $clog2(FADE_STEP_FRAMES+1).

Test Plan:
All scenarios use HOLD_FRAMES=3, FADE_STEP_FRAMES=1, MAX_INTENSITY=2, and FRAME_TICK every 4 cycles.
- Reset then REQ0=REQ1=1, DATA0=0xAAAA5555, DATA1=0x12345678 -> first tick: GNT0=1, ACK0 one pulse, DATA=0xAAAA5555; INTENSITY 0,1,2 on successive ticks.
- Continuing the previous scenario -> 3 SHOW ticks, then FADE_OUT: INTENSITY 1,0; next tick GNT1=1, GNT0=0, DATA=0x12345678, ACK1 pulse; then fade in to 2.
- Owner REQ0 drops in SHOW with REQ1=1 and hold counter=1 -> FADE_OUT begins on the next tick without waiting for hold.
- Both REQ drop in SHOW -> display stays at INTENSITY=2 with the same DATA; GNT held.
- In SHOW, owner changes DATA0 to 0x0000FFFF between ticks -> DATA updates only 1 cycle after the next FRAME_TICK, with ACK0 pulse; no mid-frame change.
- RSTN=0 for 1 cycle mid-FADE_IN (INTENSITY=1) -> next edge: INTENSITY=0, GNT=0, DATA=0, state IDLE; REQ0/REQ1 tie then goes to REQ0.
